// File: rtl/div_share_sched.sv
// rtl/div_share_sched.sv - round-robin scheduler sharing one 4-lane divider between two requesters
// Optional zero-divisor bypass enabled by defining DIV_ZERO_CHK_EN.
module div_share_sched #(
  parameter int TAG_DEPTH = 4,
  parameter int LANE_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [4*LANE_W-1:0]           req0_q,
  input  logic [LANE_W-1:0]             req0_m,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [4*LANE_W-1:0]           req1_q,
  input  logic [LANE_W-1:0]             req1_m,
  output logic                          rsp0_valid,
  input  logic                          rsp0_ready,
  output logic [4*LANE_W-1:0]           rsp0_quot,
  output logic                          rsp1_valid,
  input  logic                          rsp1_ready,
  output logic [4*LANE_W-1:0]           rsp1_quot,
  output logic                          div_enable,
  input  logic                          div_accept_out,
  input  logic                          div_ready_out,
  output logic                          div_accept_in,
  output logic [4*LANE_W-1:0]           div_q,
  output logic [LANE_W-1:0]             div_m,
  input  logic [4*LANE_W-1:0]           div_quot,
  output logic                          busy,
  output logic [$clog2(TAG_DEPTH):0]    outstanding
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};

  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rr_q, rr_d;
  logic [4*LANE_W-1:0]  div_q_q;
  logic [LANE_W-1:0]    div_m_q;

  logic                 fifo_nonempty, fifo_full;
  logic                 head_tag, head_zero, head_rsp_ready, head_done, pop;
  logic                 any_valid, grant, gnt_zero, room, can_issue, issue;
  logic [4*LANE_W-1:0]  gnt_q, rsp_quot;
  logic [LANE_W-1:0]    gnt_m;

  assign fifo_nonempty = (cnt_q != '0);
  assign fifo_full     = (cnt_q == CW'(TAG_DEPTH));
  assign head_tag      = tag_q[rd_ptr_q];

`ifdef DIV_ZERO_CHK_EN
  // A zero-divisor entry never visits the divider; its flag rides alongside the tag.
  logic [TAG_DEPTH-1:0] zero_q;
  assign head_zero = fifo_nonempty & zero_q[rd_ptr_q];
  assign gnt_zero  = (gnt_m == '0);
`else
  assign head_zero = 1'b0;
  assign gnt_zero  = 1'b0;
`endif

  assign head_rsp_ready = head_tag ? rsp1_ready : rsp0_ready;
  assign head_done      = head_zero | div_ready_out;
  assign pop            = fifo_nonempty & head_rsp_ready & head_done;
  assign div_accept_in  = fifo_nonempty & ~head_zero & head_rsp_ready;

  assign rsp_quot   = head_zero ? {4{LANE_MAX}} : div_quot;
  assign rsp0_valid = fifo_nonempty & ~head_tag & head_done;
  assign rsp1_valid = fifo_nonempty &  head_tag & head_done;
  assign rsp0_quot  = rsp_quot;
  assign rsp1_quot  = rsp_quot;

  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign gnt_q     = grant ? req1_q : req0_q;
  assign gnt_m     = grant ? req1_m : req0_m;

  // A full FIFO still takes a push when the head retires in the same cycle.
  assign room       = ~fifo_full | pop;
  assign can_issue  = ~reset & room & (gnt_zero | div_accept_out);
  assign issue      = any_valid & can_issue;
  assign req0_ready = issue & ~grant;
  assign req1_ready = issue &  grant;
  assign div_enable = issue & ~gnt_zero;

  assign div_q = div_enable ? gnt_q : div_q_q;
  assign div_m = div_enable ? gnt_m : div_m_q;

  assign busy        = fifo_nonempty;
  assign outstanding = cnt_q;

  always_comb begin
    wr_ptr_d = issue ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(issue) - CW'(pop);
    rr_d     = issue ? ~grant : rr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      div_q_q  <= '0;
      div_m_q  <= '0;
    end else begin
      if (issue) tag_q[wr_ptr_q] <= grant;
      if (div_enable) begin
        div_q_q <= gnt_q;
        div_m_q <= gnt_m;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
    end
  end

`ifdef DIV_ZERO_CHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_q <= '0;
    else if (issue) zero_q[wr_ptr_q] <= gnt_zero;
  end
`endif

endmodule

// File: tb/tb_div_share_sched.sv
// tb/tb_div_share_sched.sv - randomized bench for div_share_sched against a queue-based reference model
module tb_div_share_sched;
  localparam int TD = 4;

`ifdef DIV_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_q, req1_q;
  logic [15:0] req0_m, req1_m;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_quot, rsp1_quot;
  logic        div_enable, div_accept_out, div_ready_out, div_accept_in;
  logic [63:0] div_q, div_quot;
  logic [15:0] div_m;
  logic        busy;
  logic [2:0]  outstanding;

  div_share_sched #(.TAG_DEPTH(TD), .LANE_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_q(req0_q), .req0_m(req0_m),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_q(req1_q), .req1_m(req1_m),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_quot(rsp0_quot),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_quot(rsp1_quot),
    .div_enable(div_enable), .div_accept_out(div_accept_out), .div_ready_out(div_ready_out),
    .div_accept_in(div_accept_in), .div_q(div_q), .div_m(div_m), .div_quot(div_quot),
    .busy(busy), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Per-lane signed Q4.12 quotient, truncated to 16 bits.
  function automatic logic [63:0] qdiv(input logic [63:0] q, input logic [15:0] m);
    logic [63:0] r;
    int n, d;
    for (int i = 0; i < 4; i++) begin
      n = int'($signed(q[16*i +: 16])) * 4096;
      d = int'($signed(m));
      r[16*i +: 16] = 16'(n / d);
    end
    return r;
  endfunction

  // Reference state: outstanding tags in issue order, expected results per requester.
  bit          tagq[$];
  bit          zq[$];
  logic [63:0] exp0[$], exp1[$];
  bit          rr;
  logic [63:0] last_q;
  logic [15:0] last_m;
  logic [63:0] dq[$];
  bit          dut_gnt[$];

  task automatic step();
    int n;
    bit hd, hz, hrdy, pop, any, g, gz, can, iss, en;
    logic [15:0] gm;
    logic [63:0] gq, got, exp;
    if (reset) begin
      tagq.delete(); zq.delete(); exp0.delete(); exp1.delete();
      rr = 1'b0; last_q = '0; last_m = '0;
    end
    n    = tagq.size();
    hd   = (n > 0) && tagq[0];
    hz   = (n > 0) && zq[0];
    hrdy = hd ? rsp1_ready : rsp0_ready;
    pop  = (n > 0) && hrdy && (hz || div_ready_out);
    any  = !reset && (req0_valid || req1_valid);
    g    = (req0_valid && req1_valid) ? rr : req1_valid;
    gm   = g ? req1_m : req0_m;
    gq   = g ? req1_q : req0_q;
    gz   = ZCHK && (gm == 16'h0);
    can  = ((n < TD) || pop) && (gz || div_accept_out);
    iss  = any && can;
    en   = iss && !gz;
    #1;
    check("req0_ready", req0_ready, iss && !g);
    check("req1_ready", req1_ready, iss && g);
    check("div_enable", div_enable, en);
    check("div_q", div_q, en ? gq : last_q);
    check("div_m", div_m, en ? gm : last_m);
    check("rsp0_valid", rsp0_valid, (n > 0) && !hd && (hz || div_ready_out));
    check("rsp1_valid", rsp1_valid, (n > 0) && hd && (hz || div_ready_out));
    check("div_accept_in", div_accept_in, (n > 0) && !hz && hrdy);
    check("outstanding", outstanding, n);
    check("busy", busy, n != 0);
    if (req0_ready || req1_ready) dut_gnt.push_back(req1_ready);
    if (pop) begin
      got = hd ? rsp1_quot : rsp0_quot;
      if (hd) exp = (exp1.size() > 0) ? exp1.pop_front() : 64'hx;
      else    exp = (exp0.size() > 0) ? exp0.pop_front() : 64'hx;
      check(hd ? "rsp1_quot" : "rsp0_quot", got, exp);
      void'(tagq.pop_front());
      void'(zq.pop_front());
    end
    if (iss) begin
      tagq.push_back(g);
      zq.push_back(gz);
      if (g) exp1.push_back(gz ? {4{16'h7FFF}} : qdiv(gq, gm));
      else   exp0.push_back(gz ? {4{16'h7FFF}} : qdiv(gq, gm));
      rr = !g;
      if (en) begin last_q = gq; last_m = gm; end
    end
    if (!reset && div_ready_out && div_accept_in && dq.size() > 0) void'(dq.pop_front());
    if (div_enable && div_accept_out) dq.push_back(qdiv(div_q, div_m));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int pv0, input int pv1, input int pacc, input int pdro,
                       input int pr0, input int pr1);
    req0_valid     = int'($urandom_range(99)) < pv0;
    req1_valid     = int'($urandom_range(99)) < pv1;
    req0_q         = {$urandom, $urandom};
    req1_q         = {$urandom, $urandom};
    req0_m         = 16'($urandom) | 16'h1;
    req1_m         = 16'($urandom) | 16'h1;
    div_accept_out = int'($urandom_range(99)) < pacc;
    rsp0_ready     = int'($urandom_range(99)) < pr0;
    rsp1_ready     = int'($urandom_range(99)) < pr1;
    div_ready_out  = (dq.size() > 0) && (int'($urandom_range(99)) < pdro);
    div_quot       = (dq.size() > 0) ? dq[0] : {$urandom, $urandom};
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && tagq.size() > 0; i++) begin
      drive(0, 0, 100, 100, 100, 100);
      step();
    end
    check("drained", outstanding, 0);
  endtask

  initial begin
    int prev;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    div_quot = '0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Single issue with a known quotient.
    drive(0, 0, 100, 0, 0, 0);
    req0_valid = 1'b1; req0_q = 64'h5000_2800_1000_0800; req0_m = 16'h5000;
    step();
    drive(0, 0, 0, 100, 100, 100);
    check("div_model_fed", dq.size(), 1);
    #1;
    check("single_quot", rsp0_quot, 64'h1000_0800_0333_0199);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Alternating grants from a fresh round-robin pointer.
    reset = 1'b1; step(); reset = 1'b0;
    dq.delete(); dut_gnt.delete();
    for (int i = 0; i < 100 && dut_gnt.size() < 8; i++) begin
      drive(100, 100, 100, 40, 100, 100);
      step();
    end
    check("alt_count", dut_gnt.size() >= 8, 1);
    for (int i = 0; i < 8 && i < dut_gnt.size(); i++) check("alt_order", dut_gnt[i], i % 2);
    drain();

    // Fill the tag FIFO, then swap one result for one issue.
    for (int i = 0; i < 6; i++) begin
      drive(100, 100, 100, 0, 100, 100);
      step();
    end
    check("full_count", outstanding, 4);
    drive(100, 100, 100, 100, 100, 100);
    step();
    check("full_swap", outstanding, 4);

    // Head requester backpressure.
    drive(0, 0, 0, 100, 0, 0);
    prev = int'(outstanding);
    step();
    check("bp_hold", outstanding, prev);
    drive(0, 0, 0, 100, 100, 100);
    step();
    check("bp_pop", outstanding, prev - 1);
    drain();

    for (int i = 0; i < 1500; i++) begin
      drive(60, 60, 70, 50, 70, 70);
      step();
    end
    drain();

`ifdef DIV_ZERO_CHK_EN
    drive(0, 0, 100, 0, 0, 0);
    req0_valid = 1'b1; step();
    drive(0, 0, 0, 0, 0, 0);
    req1_valid = 1'b1; req1_m = 16'h0; step();
    drive(0, 0, 100, 0, 0, 0);
    req0_valid = 1'b1; step();
    drive(0, 0, 0, 0, 100, 100);
    step();
    check("zero_wait", rsp1_valid, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 100, 100, 100);
      step();
    end
    check("zero_done", outstanding, 0);
`endif

    // Reset with two operations outstanding; a late divider result must be refused.
    drive(0, 0, 100, 0, 0, 0); req0_valid = 1'b1; step();
    drive(0, 0, 100, 0, 0, 0); req0_valid = 1'b1; step();
    check("pre_reset", outstanding, 2);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    check("reset_clear", outstanding, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 100, 100);
    div_ready_out = 1'b1;
    div_quot = 64'hDEAD_BEEF_0000_1111;
    step();
    check("late_refused", div_accept_in, 0);
    dq.delete();
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Schedules the shared 4-lane fixed-point divider (64-bit packed dividend of four Q4.12 lanes, one Q4.12 divisor) between two requesters, e.g. the two adj(H)/det(H) producers in the ZF inverse path.
- Round-robin arbitration at the divider input.
- Each issue is tagged in an in-order tag FIFO; each divider result is routed back to the requester that issued it.
- Divider backpressure is honoured on both sides.

Parameters:
- TAG_DEPTH, 4: max issued-but-unreturned operations; power of 2, ≥2.
- LANE_W, 16: lane width; dividend is 4*LANE_W bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation taken this cycle.
- req0_q  in  4*LANE_W  requester 0 packed dividend.
- req0_m  in  LANE_W  requester 0 divisor.
- req1_valid / req1_ready / req1_q / req1_m  same as requester 0.
- rsp0_valid  out  1  result for requester 0.
- rsp0_ready  in  1  requester 0 accepts result.
- rsp0_quot  out  4*LANE_W  result for requester 0.
- rsp1_valid / rsp1_ready / rsp1_quot  same as requester 0.
- div_enable  out  1  issue strobe to divider.
- div_accept_out  in  1  divider can take an input.
- div_ready_out  in  1  divider result valid.
- div_accept_in  out  1  scheduler accepts divider result.
- div_q  out  4*LANE_W  dividend to divider.
- div_m  out  LANE_W  divisor to divider.
- div_quot  in  4*LANE_W  divider result.
- busy  out  1  at least one operation outstanding.
- outstanding  out  $clog2(TAG_DEPTH)+1  outstanding-operation count.

Behaviour:
- Reset (async, active-high) values:
  - All *_ready, rsp*_valid, div_enable, div_accept_in, busy = 0; outstanding = 0.
  - div_q, div_m = 0.
  - RR pointer = requester 0; tag FIFO emptied.
- Reset mid-operation: all outstanding tags discarded; divider results arriving after reset release with an empty FIFO are not accepted (div_accept_in = 0).
- Issue condition (combinational, same cycle): can_issue = div_accept_out & !fifo_full.
- Grant:
  - If both requesters are valid, the RR pointer picks; otherwise the sole valid one is granted.
  - reqX_ready = granted(X) & can_issue. Only one ready is high per cycle.
- Issue cycle (reqX_valid & reqX_ready):
  - div_enable = 1; div_q/div_m = that requester's q/m.
  - Tag X pushed into the FIFO; RR pointer moves to the other requester.
  - Outside an issue cycle: div_enable = 0; div_q/div_m hold their last issued values (registered copy, no glitching).
- Divider returns results strictly in issue order. FIFO head tag selects the destination.
- Return path (combinational):
  - rspX_valid = div_ready_out & fifo_nonempty & (head==X).
  - rspX_quot = div_quot.
  - div_accept_in = fifo_nonempty & rsp_ready of the head requester.
  - Pop occurs on div_ready_out & div_accept_in.
- Latency: zero scheduler latency in both directions; total latency equals the divider latency.
- Simultaneous push and pop in one cycle is legal. Count is unchanged. Push is permitted even when full if a pop occurs that cycle.
- FIFO full: issue blocked; both req*_ready = 0.
- FIFO empty: div_accept_in = 0; rsp*_valid = 0.
- FIFO pointers wrap modulo TAG_DEPTH.
- outstanding = FIFO occupancy; busy = (outstanding != 0).

Optional Feature:
- Macro: DIV_ZERO_CHK_EN.
- Defined:
  - Issue with req m == 0 is accepted without div_enable and without needing div_accept_out; only !fifo_full is required.
  - A tag carrying a zero flag is pushed.
  - When that entry reaches the head, rspX_valid = 1 independent of div_ready_out, with rspX_quot = {4{16'h7FFF}} (LANE_W-bit max positive per lane).
  - The entry pops on rspX_ready; div_accept_in = 0 for that entry.
  - Ordering versus real divider results is preserved.
- Undefined: m == 0 is forwarded to the divider like any other value; the result is whatever the divider produces.

Test Plan:
- Reset, no requests → all outputs 0; busy = 0; outstanding = 0.
- Single issue from req0 (q = 64'h5000_2800_1000_0800, m = 16'h5000), div_accept_out = 1 → one cycle with div_enable = 1 and div_q/div_m equal to those values. Divider returns 64'h1000_0800_0333_0199 → rsp0_valid with that value; rsp1_valid stays 0; busy drops after the pop.
- Both requesters valid every cycle for 8 issues → grants alternate req0, req1, req0, … starting with req0; results are routed to the matching requester in order.
- Hold div_ready_out = 0 and issue TAG_DEPTH = 4 ops → fourth issue fills the FIFO; both req*_ready = 0; outstanding = 4. Then return one result while a request is pending → pop and push occur in the same cycle; outstanding stays 4.
- Head requester holds rsp_ready = 0 while div_ready_out = 1 → div_accept_in = 0, no pop. Raise rsp_ready → one pop.
- With DIV_ZERO_CHK_EN: req1 issues m = 0 between two normal req0 ops → no div_enable for the m = 0 op. req1 receives 64'h7FFF_7FFF_7FFF_7FFF only after the first req0 result; the second req0 result is returned after it. Also assert reset with 2 ops outstanding → outstanding = 0 and a late div_ready_out is not accepted.
